dmem_resp: RTL and testbench

Multi-cycle data-memory responder on the CPU load/store port (ramR/ramW/addr/dataW/dataR). It adds a ready/err handshake, programmable wait states, byte/halfword/word stores, aligned load extraction and misalignment detection. The CPU's load path still does sign/zero extension by funct3. This block returns raw lane-aligned data, zero-filled above the accessed width.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/dmem_align.sv | 50 +++++
 rtl/dmem_resp.sv | 118 +++++++++++
 tb/tb_dmem_resp.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: funct3 access-size codes, the data-memory
// responder state encoding and its latched request record.
package cpu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  typedef struct packed {
    logic            rd;
    logic            wr;
    logic [2:0]      f3;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wd;
  } dmem_req_t;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane steering for the data memory: store byte enables and replicated
// write data, load extraction (zero-filled) and the reject flag.
module dmem_align
  import cpu_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lane,
  input  logic            store,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      be,
  output logic [XLEN-1:0] wshift,
  output logic            bad,
  output logic [XLEN-1:0] rdata
);

  always_comb begin
    be     = '0;
    wshift = '0;
    bad    = 1'b0;
    rdata  = '0;
    case (funct3)
      F3_B, F3_BU: begin
        // unsigned variants exist only for loads
        bad    = store && (funct3 == F3_BU);
        be     = 4'b0001 << lane;
        wshift = {4{wdata[7:0]}};
        rdata  = {24'd0, rword[{lane, 3'b000} +: 8]};
      end
      F3_H, F3_HU: begin
        bad    = lane[0] || (store && (funct3 == F3_HU));
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wshift = {2{wdata[15:0]}};
        rdata  = {16'd0, (lane[1] ? rword[31:16] : rword[15:0])};
      end
      F3_W: begin
        bad    = (lane != 2'b00);
        be     = 4'b1111;
        wshift = wdata;
        rdata  = rword;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      be    = '0;
      rdata = '0;
    end
  end

endmodule

// File: rtl/dmem_resp.sv
// Multi-cycle data-memory responder: IDLE/WAIT/RESP handshake with
// programmable wait states over a byte-lane memory array.
module dmem_resp
  import cpu_pkg::*;
#(
  parameter int n     = 32,
  parameter int depth = 256,
  parameter int waits = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         ramR,
  input  logic         ramW,
  input  logic [2:0]   funct3,
  input  logic [n-1:0] addr,
  input  logic [n-1:0] dataW,
  output logic [n-1:0] dataR,
  output logic         ready,
  output logic         err
);

  localparam int NUM_LANES = n / 8;
  localparam int AW        = $clog2(depth);

  dmem_state_t               state, nxt;
  logic [3:0]                cnt;
  dmem_req_t                 lat, cur;
  logic                      req;
  logic [AW-1:0]             idx;
  logic [NUM_LANES-1:0][7:0] rword, wsh;
  logic [NUM_LANES-1:0]      be;
  logic [n-1:0]              rdata, rsp_data;
  logic                      bad, rsp_err, we;

  assign req = ramR | ramW;

  // Live inputs while idle (zero-wait responses), latched copy afterwards.
  always_comb begin
    cur = lat;
    if (state == IDLE)
      cur = '{rd: ramR, wr: ramW, f3: funct3, addr: addr, wd: dataW};
  end

  assign idx = cur.addr[AW+1:2];

  dmem_align u_align (
    .funct3 (cur.f3),
    .lane   (cur.addr[1:0]),
    .store  (cur.wr),
    .wdata  (cur.wd),
    .rword  (rword),
    .be     (be),
    .wshift (wsh),
    .bad    (bad),
    .rdata  (rdata)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (req) nxt = (waits == 0) ? RESP : WAIT;
      WAIT:    if (cnt <= 4'd1) nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_comb begin
    rsp_err  = (cur.rd && cur.wr) || bad;
    rsp_data = (cur.rd && !rsp_err) ? rdata : '0;
    we       = (state == RESP) && cur.wr && !rsp_err;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      lat <= '0;
    end else if (state == IDLE && req) begin
      cnt <= 4'(waits);
      lat <= cur;
    end else if (state == WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response fields are registered on entry to RESP and cleared otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ready <= 1'b0;
      err   <= 1'b0;
      dataR <= '0;
    end else if (nxt == RESP) begin
      ready <= 1'b1;
      err   <= rsp_err;
      dataR <= rsp_data;
    end else begin
      ready <= 1'b0;
      err   <= 1'b0;
      dataR <= '0;
    end
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    logic [7:0] ram [depth];

    assign rword[i] = ram[idx];

    always_ff @(posedge clock) begin
      if (we && be[i]) ram[idx] <= wsh[i];
    end
  end

endmodule

// File: tb/tb_dmem_resp.sv
// Directed bench for dmem_resp: one instance with one wait state, one with none.
module tb_dmem_resp;
  import cpu_pkg::*;

  logic        clock;
  logic        rst_n;
  logic        rr [2];
  logic        ww [2];
  logic [2:0]  f3 [2];
  logic [31:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] dr [2];
  logic        rdy [2];
  logic        er [2];

  int total = 0;
  int bad   = 0;

  dmem_resp #(.n(32), .depth(256), .waits(1)) u0 (
    .clock(clock), .reset(rst_n), .ramR(rr[0]), .ramW(ww[0]), .funct3(f3[0]),
    .addr(ad[0]), .dataW(wd[0]), .dataR(dr[0]), .ready(rdy[0]), .err(er[0])
  );

  dmem_resp #(.n(32), .depth(256), .waits(0)) u1 (
    .clock(clock), .reset(rst_n), .ramR(rr[1]), .ramW(ww[1]), .funct3(f3[1]),
    .addr(ad[1]), .dataW(wd[1]), .dataR(dr[1]), .ready(rdy[1]), .err(er[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  // One access on instance u; checks latency, err, data and pulse width.
  task automatic acc(input int u, input logic r, input logic w, input logic [2:0] f,
                     input logic [31:0] a, input logic [31:0] d,
                     input logic exp_err, input logic [31:0] exp_data, input string tag);
    int lat;
    logic [31:0] got_d;
    logic got_e;
    @(negedge clock);
    rr[u] = r; ww[u] = w; f3[u] = f; ad[u] = a; wd[u] = d;
    lat = 0;
    do begin
      @(posedge clock); #1;
      lat++;
    end while (!rdy[u] && lat < 40);
    got_d = dr[u];
    got_e = er[u];
    rr[u] = 1'b0; ww[u] = 1'b0;
    chk({tag, ":lat"}, 32'(lat), (u == 0) ? 32'd2 : 32'd1);
    chk({tag, ":err"}, {31'd0, got_e}, {31'd0, exp_err});
    chk({tag, ":data"}, got_d, exp_data);
    @(posedge clock); #1;
    chk({tag, ":pulse"}, {31'd0, rdy[u]}, 32'd0);
  endtask

  initial begin
    logic [3:0] pat;
    logic seen;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rr[i] = 1'b0; ww[i] = 1'b0; f3[i] = 3'b000; ad[i] = '0; wd[i] = '0;
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    for (int i = 0; i < 2; i++) begin
      chk("rst:ready", {31'd0, rdy[i]}, 32'd0);
      chk("rst:err",   {31'd0, er[i]},  32'd0);
      chk("rst:data",  dr[i],           32'd0);
    end
    rst_n = 1'b1;

    // one wait state: word/byte/half stores and loads
    acc(0, 0, 1, F3_W,  32'h10, 32'hDEADBEEF, 0, 32'h0,        "sw10");
    acc(0, 1, 0, F3_W,  32'h10, 32'h0,        0, 32'hDEADBEEF, "lw10a");
    acc(0, 0, 1, F3_B,  32'h11, 32'h000000AA, 0, 32'h0,        "sb11");
    acc(0, 1, 0, F3_W,  32'h10, 32'h0,        0, 32'hDEADAAEF, "lw10b");
    acc(0, 1, 0, F3_BU, 32'h11, 32'h0,        0, 32'h000000AA, "lbu11");
    acc(0, 1, 0, F3_B,  32'h10, 32'h0,        0, 32'h000000EF, "lb10");
    acc(0, 0, 1, F3_H,  32'h12, 32'h00001234, 0, 32'h0,        "sh12");
    acc(0, 1, 0, F3_W,  32'h10, 32'h0,        0, 32'h1234AAEF, "lw10c");
    acc(0, 1, 0, F3_HU, 32'h12, 32'h0,        0, 32'h00001234, "lhu12");
    acc(0, 1, 0, F3_H,  32'h10, 32'h0,        0, 32'h0000AAEF, "lh10");

    // rejected accesses leave memory untouched
    acc(0, 1, 0, F3_H,  32'h13, 32'h0,        1, 32'h0,        "lh13");
    acc(0, 0, 1, F3_H,  32'h13, 32'h00005555, 1, 32'h0,        "sh13");
    acc(0, 0, 1, F3_W,  32'h12, 32'hFFFFFFFF, 1, 32'h0,        "sw12");
    acc(0, 0, 1, F3_BU, 32'h10, 32'h00000077, 1, 32'h0,        "sbu10");
    acc(0, 1, 0, 3'b011, 32'h10, 32'h0,       1, 32'h0,        "ld011");
    acc(0, 1, 0, 3'b110, 32'h10, 32'h0,       1, 32'h0,        "ld110");
    acc(0, 1, 0, F3_W,  32'h10, 32'h0,        0, 32'h1234AAEF, "lw10d");

    // zero waits: back-to-back stores with the request held
    @(negedge clock);
    ww[1] = 1'b1; f3[1] = F3_W; ad[1] = 32'h0; wd[1] = 32'h01020304;
    pat = '0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clock); #1;
      pat[i] = rdy[1];
      if (i == 0) begin ad[1] = 32'h4; wd[1] = 32'hA5A55A5A; end
      if (i == 2) ww[1] = 1'b0;
    end
    chk("b2b:pat", {28'd0, pat}, 32'h5);
    acc(1, 1, 0, F3_W, 32'h0, 32'h0,        0, 32'h01020304, "w0:lw0");
    acc(1, 1, 0, F3_W, 32'h4, 32'h0,        0, 32'hA5A55A5A, "w0:lw4");
    acc(1, 1, 1, F3_W, 32'h4, 32'hFFFFFFFF, 1, 32'h0,        "w0:both");
    acc(1, 1, 0, F3_W, 32'h4, 32'h0,        0, 32'hA5A55A5A, "w0:lw4b");

    // address wrap modulo depth words
    acc(0, 0, 1, F3_W, 32'h400, 32'h00000055, 0, 32'h0,        "sw400");
    acc(0, 1, 0, F3_W, 32'h0,   32'h0,        0, 32'h00000055, "lw0wrap");

    // reset during WAIT aborts the store
    acc(0, 0, 1, F3_W, 32'h20, 32'hCAFEF00D, 0, 32'h0, "sw20");
    @(negedge clock);
    ww[0] = 1'b1; f3[0] = F3_W; ad[0] = 32'h20; wd[0] = 32'h0BADBEEF;
    @(posedge clock); #1;
    seen = rdy[0];
    @(negedge clock);
    rst_n = 1'b0;
    #1;
    chk("arst:ready", {31'd0, rdy[0]}, 32'd0);
    chk("arst:err",   {31'd0, er[0]},  32'd0);
    chk("arst:data",  dr[0],           32'd0);
    ww[0] = 1'b0;
    repeat (2) begin @(posedge clock); #1; seen = seen | rdy[0]; end
    @(negedge clock);
    rst_n = 1'b1;
    repeat (3) begin @(posedge clock); #1; seen = seen | rdy[0]; end
    chk("arst:noready", {31'd0, seen}, 32'd0);
    acc(0, 1, 0, F3_W, 32'h20, 32'h0, 0, 32'hCAFEF00D, "lw20");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
